// File: rtl/atm_pin_entry.sv
// atm_pin_entry: keypad PIN collection and verification ahead of the ATM
// controller. Digits are buffered while a card is present. ENTER triggers a
// one-cycle CHECK that either grants (pin_valid) or counts a failed attempt.
// The account locks after MAX_TRIES failures, and only reset releases it.
//
// Optional feature macro: PIN_TIMEOUT_EN. When it is defined, TIMEOUT_CYCLES
// consecutive key-free cycles in COLLECT count as a failed attempt. When it
// is undefined, no idle counter is built.
//
// Handshake: key_valid is a one-cycle strobe with no back-pressure. A key is
// consumed on the rising edge where key_valid=1, and only if the current
// state accepts keys. Otherwise the key is silently dropped.
// state_o exposes the FSM state for debug and checker binding.
module atm_pin_entry #(
    parameter int unsigned               PIN_DIGITS     = 4,
    parameter logic [4*PIN_DIGITS-1:0]   PIN_VALUE      = 16'h1234,
    parameter int unsigned               MAX_TRIES      = 3,
    parameter int unsigned               TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       card_inserted,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       pin_valid,
    output logic       pin_error,
    output logic       locked,
    output logic [2:0] digit_count,
    output logic [1:0] attempt_count,
    output logic [2:0] state_o
);

    localparam int unsigned BW       = 4 * PIN_DIGITS;
    localparam logic [2:0]  DIGITS_C = 3'(PIN_DIGITS);
    localparam logic [1:0]  TRIES_C  = 2'(MAX_TRIES);
    localparam logic [3:0]  KEY_CLR  = 4'hA;
    localparam logic [3:0]  KEY_ENT  = 4'hB;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_CHECK   = 3'd2,
        S_GRANTED = 3'd3,
        S_LOCKED  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    att_q, att_d;
    logic [1:0]    att_inc;
    logic          err_d;
    logic          fail;
    logic          is_digit;
    logic          timer_expire;

    assign is_digit = (key_code <= 4'd9);
    assign att_inc  = att_q + 2'd1;

`ifdef PIN_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] timer_q, timer_d;

    // The idle limit is reached when the last allowed key-free cycle also has no key.
    assign timer_expire = (state_q == S_COLLECT) && card_inserted && !key_valid
                          && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // The idle counter restarts on any key, on entry into COLLECT and after each expiry.
    always_comb begin
        timer_d = timer_q + 1'b1;
        if (state_q != S_COLLECT || state_d != S_COLLECT || key_valid || timer_expire) begin
            timer_d = '0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`else
    assign timer_expire = 1'b0;
`endif

    // Next-state logic. A failed attempt from CHECK or from a timeout shares one tail.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        att_d   = att_q;
        err_d   = 1'b0;
        fail    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (card_inserted) begin
                    state_d = S_COLLECT;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_COLLECT: begin
                if (!card_inserted) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (key_valid) begin
                    if (is_digit) begin
                        if (cnt_q < DIGITS_C) begin
                            buf_d = (buf_q << 4) | BW'(key_code);
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (key_code == KEY_CLR) begin
                        buf_d = '0;
                        cnt_d = '0;
                    end else if (key_code == KEY_ENT) begin
                        state_d = S_CHECK;
                    end
                end else if (timer_expire) begin
                    fail = 1'b1;
                end
            end
            S_CHECK: begin
                if (!card_inserted) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == DIGITS_C && buf_q == PIN_VALUE) begin
                    state_d = S_GRANTED;
                    att_d   = '0;
                end else begin
                    fail = 1'b1;
                end
            end
            S_GRANTED: begin
                if (!card_inserted) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_LOCKED: begin
                state_d = S_LOCKED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (fail) begin
            err_d   = 1'b1;
            att_d   = att_inc;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = (att_inc == TRIES_C) ? S_LOCKED : S_COLLECT;
        end
    end

    // State and registered outputs. The level outputs are decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            att_q     <= '0;
            pin_error <= 1'b0;
            pin_valid <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            att_q     <= att_d;
            pin_error <= err_d;
            pin_valid <= (state_d == S_GRANTED);
            locked    <= (state_d == S_LOCKED);
        end
    end

    assign digit_count   = cnt_q;
    assign attempt_count = att_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Bench for atm_pin_entry. A high-level model holds the typed digits in a
// queue and the attempts as an integer. Each attempt outcome is queued when
// ENTER (or a timeout) is issued. A negedge monitor pops and compares an
// entry whenever the DUT pulses pin_error or raises pin_valid.
module tb_atm_pin_entry;
  logic       clk = 1'b0;
  logic       reset;
  logic       card_inserted;
  logic       key_valid;
  logic [3:0] key_code;
  logic       pin_valid;
  logic       pin_error;
  logic       locked;
  logic [2:0] digit_count;
  logic [1:0] attempt_count;
  logic [2:0] state_o;

  // clock / reset
  always #5 clk = ~clk;

  atm_pin_entry dut (
    .clk           (clk),
    .reset         (reset),
    .card_inserted (card_inserted),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .pin_valid     (pin_valid),
    .pin_error     (pin_error),
    .locked        (locked),
    .digit_count   (digit_count),
    .attempt_count (attempt_count),
    .state_o       (state_o)
  );

  int errors = 0;
  int checks = 0;

  // outcome word: {pin_valid, pin_error, locked, attempt_count[1:0], digit_count[2:0]}
  logic [7:0] exp_q[$];
  logic [7:0] mon_obs;
  logic [7:0] mon_exp;
  logic       pv_prev = 1'b0;

  // reference model
  int m_digits[$];
  int m_attempts;
  bit m_card;
  bit m_collect;
  bit m_granted;
  bit m_locked;
  int pin_ref[4] = '{1, 2, 3, 4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b1 && (pin_error === 1'b1 || (pin_valid === 1'b1 && !pv_prev))) begin
      mon_obs = {pin_valid, pin_error, locked, attempt_count, digit_count};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_outcome: got %0h expected none at %0t", mon_obs, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          errors++;
          $display("FAIL outcome: got %0h expected %0h at %0t", mon_obs, mon_exp, $time);
        end
      end
    end
    pv_prev = pin_valid;
  end

  function automatic void model_fail();
    m_attempts++;
    m_digits.delete();
    if (m_attempts >= 3) begin
      m_locked  = 1'b1;
      m_collect = 1'b0;
    end
    exp_q.push_back({1'b0, 1'b1, m_locked, 2'(m_attempts), 3'd0});
  endfunction

  function automatic void model_key(input logic [3:0] code);
    bit match;
    if (!(m_card && m_collect)) return;
    if (code <= 4'd9) begin
      if (m_digits.size() < 4) m_digits.push_back(int'(code));
    end else if (code == 4'hA) begin
      m_digits.delete();
    end else if (code == 4'hB) begin
      match = (m_digits.size() == 4);
      if (match) for (int i = 0; i < 4; i++) if (m_digits[i] != pin_ref[i]) match = 1'b0;
      if (match) begin
        m_attempts = 0;
        m_granted  = 1'b1;
        m_collect  = 1'b0;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 2'd0, 3'(m_digits.size())});
      end else begin
        model_fail();
      end
    end
  endfunction

  task automatic check_levels(input string tag);
    check({tag, "_digits"}, 32'(digit_count), 32'(m_digits.size()));
    check({tag, "_attempts"}, 32'(attempt_count), 32'(m_attempts));
    check({tag, "_locked"}, 32'(locked), 32'(m_locked));
    check({tag, "_pin_valid"}, 32'(pin_valid), 32'(m_granted));
  endtask

  // driver tasks
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    model_key(code);
    @(negedge clk);
    key_valid = 1'b0;
    if (code == 4'hB) @(negedge clk);
    else check("no_error", 32'(pin_error), 32'd0);
    check_levels("key");
  endtask

  task automatic card_in();
    @(negedge clk);
    card_inserted = 1'b1;
    m_card = 1'b1;
    if (!m_locked && !m_granted) begin
      m_collect = 1'b1;
      m_digits.delete();
    end
    @(negedge clk);
    check_levels("card_in");
  endtask

  task automatic card_out(input bit with_key, input logic [3:0] code);
    @(negedge clk);
    card_inserted = 1'b0;
    key_valid     = with_key;
    key_code      = code;
    m_card = 1'b0;
    if (!m_locked) begin
      m_granted = 1'b0;
      m_collect = 1'b0;
      m_digits.delete();
    end
    @(negedge clk);
    key_valid = 1'b0;
    check_levels("card_out");
    check("card_out_error", 32'(pin_error), 32'd0);
    if (!m_locked) check("card_out_idle", 32'(state_o), 32'd0);
  endtask

  task automatic do_reset();
    check("pending_outcomes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    #2;
    reset = 1'b0;
    card_inserted = 1'b0;
    key_valid = 1'b0;
    #1;
    check("async_locked", 32'(locked), 32'd0);
    check("async_pin_valid", 32'(pin_valid), 32'd0);
    check("async_attempts", 32'(attempt_count), 32'd0);
    check("async_digits", 32'(digit_count), 32'd0);
    m_digits.delete();
    m_attempts = 0;
    m_card = 1'b0;
    m_collect = 1'b0;
    m_granted = 1'b0;
    m_locked = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_levels("reset");
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_error", 32'(pin_error), 32'd0);
  endtask

  task automatic enter_pin(input int d0, input int d1, input int d2, input int d3);
    press(4'(d0));
    press(4'(d1));
    press(4'(d2));
    press(4'(d3));
  endtask

  int mode;
  int nk;
  logic [3:0] rk;

  initial begin
    reset = 1'b1;
    card_inserted = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    do_reset();

    // keys with no card are ignored
    press(4'd1);

    // correct PIN, then card removal
    card_in();
    enter_pin(1, 2, 3, 4);
    press(4'hB);
    card_out(1'b0, 4'h0);

    // lockout with three wrong entries; correct PIN and reinsertion afterwards do nothing
    card_in();
    for (int t = 0; t < 3; t++) begin
      enter_pin(9, 9, 9, 9);
      press(4'hB);
    end
    enter_pin(1, 2, 3, 4);
    press(4'hB);
    card_out(1'b0, 4'h0);
    card_in();
    enter_pin(1, 2, 3, 4);
    press(4'hB);
    card_out(1'b0, 4'h0);
    do_reset();

    // short entry, then long entry with a dropped fifth digit
    card_in();
    press(4'd1); press(4'd2); press(4'd3);
    press(4'hB);
    enter_pin(1, 2, 3, 4);
    press(4'd5);
    press(4'hB);
    card_out(1'b0, 4'h0);

    // CLEAR mid-entry; ignored codes C-F
    card_in();
    press(4'd7); press(4'd7);
    press(4'hA);
    press(4'hC); press(4'hF);
    enter_pin(1, 2, 3, 4);
    press(4'hB);
    card_out(1'b0, 4'h0);

    // attempt retention across card removal; key coincident with removal is dropped
    card_in();
    press(4'd5);
    press(4'hB);
    press(4'd1);
    card_out(1'b1, 4'd2);
    card_in();
    enter_pin(1, 2, 3, 4);
    press(4'hB);

    // digit pressed while in CHECK is ignored
    card_out(1'b0, 4'h0);
    card_in();
    enter_pin(1, 2, 3, 4);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'hB;
    model_key(4'hB);
    @(negedge clk);
    key_code = 4'd5;
    @(negedge clk);
    key_valid = 1'b0;
    check_levels("check_key");
    card_out(1'b0, 4'h0);

`ifdef PIN_TIMEOUT_EN
    // timeout after 16 idle cycles; a key on the 16th cycle prevents it
    card_in();
    press(4'd1);
    model_fail();
    repeat (16) @(negedge clk);
    check_levels("timeout");
    press(4'd1);
    repeat (15) @(negedge clk);
    press(4'd2);
    card_out(1'b0, 4'h0);
`endif

    // randomized sessions
    for (int s = 0; s < 60; s++) begin
      card_in();
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        enter_pin(1, 2, 3, 4);
      end else if (mode == 1) begin
        nk = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) press(4'((i == nk) ? $urandom_range(0, 9) : pin_ref[i]));
      end else if (mode == 2) begin
        nk = $urandom_range(0, 6);
        for (int i = 0; i < nk; i++) begin
          rk = 4'($urandom_range(0, 15));
          if (rk == 4'hB) rk = 4'hA;
          press(rk);
        end
      end else begin
        enter_pin(1, 2, 3, 4);
        press(4'($urandom_range(0, 9)));
      end
      press(4'hB);
      card_out(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
      if (m_locked || $urandom_range(0, 7) == 0) do_reset();
    end

    repeat (3) @(negedge clk);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/atm_pin_entry.md
# atm_pin_entry

Keypad PIN entry and verification stage sitting directly upstream of the ATM controller. It collects BCD digits from the keypad while a card is inserted and compares them against the stored PIN on ENTER. It drives the controller's `pin_valid` input, counts failed attempts and locks the account after `MAX_TRIES` failures. An optional inactivity timeout counts a stalled entry as a failed attempt.

## Interface
- `PIN_DIGITS`, 4, number of BCD digits in a PIN; legal range 1–7.
- `PIN_VALUE`, 16'h1234, stored PIN, one BCD nibble per digit, most-significant digit first; width is 4*`PIN_DIGITS`.
- `MAX_TRIES`, 3, failed attempts before lock; legal range 1–3.
- `TIMEOUT_CYCLES`, 16, idle cycles in COLLECT before a timeout failure; only used with `PIN_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `card_inserted`  in  1  level; high while a card is present.
- `key_valid`  in  1  one-cycle strobe qualifying `key_code`.
- `key_code`  in  4  0–9 are digits, 4'hA is CLEAR, 4'hB is ENTER; 4'hC–4'hF are ignored.
- `pin_valid`  out  1  level, high while PIN is verified; feeds the controller's `pin_valid`.
- `pin_error`  out  1  one-cycle pulse per failed attempt.
- `locked`  out  1  level, account locked.
- `digit_count`  out  3  digits currently buffered.
- `attempt_count`  out  2  failed attempts so far.

## Operation
- States: IDLE, COLLECT, CHECK, GRANTED, LOCKED.
- Reset: state IDLE, buffer 0, and all outputs 0.
- IDLE:
  - `card_inserted`=1 → COLLECT with buffer and `digit_count` cleared.
  - Keys are ignored.
- COLLECT, digit key:
  - If `digit_count` < `PIN_DIGITS`, shift the nibble into the buffer LSB and increment `digit_count`.
  - Otherwise the digit is dropped and nothing changes.
- COLLECT, other keys:
  - CLEAR: buffer=0, `digit_count`=0, stay in COLLECT.
  - ENTER: → CHECK, regardless of `digit_count`.
  - Codes 4'hC–4'hF: no effect.
- CHECK lasts exactly one cycle; keys arriving in it are ignored.
  - Match means `digit_count`==`PIN_DIGITS` and buffer==`PIN_VALUE`.
  - Match → GRANTED, `attempt_count` cleared.
  - Mismatch → `pin_error` pulse and `attempt_count`+1. If the new count equals `MAX_TRIES` → LOCKED; otherwise → COLLECT with buffer cleared.
- GRANTED:
  - `pin_valid`=1 and keys are ignored.
  - `card_inserted`=0 → IDLE and `pin_valid`=0 on the same edge.
- LOCKED:
  - `locked`=1 and all keys are ignored.
  - Card removal and reinsertion do not clear the lock; only `reset` leaves LOCKED.
- Card removal in COLLECT or CHECK → IDLE with buffer cleared. `attempt_count` is retained, so removing the card does not bypass the attempt limit.
- `attempt_count` clears only on a successful match or on `reset`.

## Timing
- All outputs are registered.
- A key sampled at edge k updates `digit_count` from edge k.
- ENTER sampled at edge k: state is CHECK after edge k. `pin_valid` rises, or `pin_error` pulses, at edge k+1.
- `locked` rises at the same edge as the final `pin_error` pulse.
- `key_valid` coincident with `card_inserted` falling: card removal wins and the key is dropped.
- With `PIN_TIMEOUT_EN`, `key_valid` in the cycle the timer expires wins: the key is accepted and the timer restarts.
- `reset` asserted mid-operation clears everything immediately, asynchronously, including LOCKED.

## Configuration
- `PIN_TIMEOUT_EN` defined:
  - An idle counter runs in COLLECT and restarts on any `key_valid` and on entry to COLLECT.
  - After `TIMEOUT_CYCLES` consecutive cycles with no key, the block takes the mismatch path of CHECK (`pin_error`, attempt increment, possible lock).
- `PIN_TIMEOUT_EN` undefined:
  - No counter is built; COLLECT waits indefinitely.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- Correct PIN: card in, keys 1,2,3,4, ENTER at edge k → `pin_valid`=1 from k+1, `pin_error` stays 0. Card out → `pin_valid`=0 and state IDLE.
- Lockout: three entries of 9,9,9,9, ENTER → three one-cycle `pin_error` pulses and `attempt_count` going 1, 2, 3. `locked`=1 with the third pulse. The correct PIN and a card reinsertion afterwards leave `pin_valid`=0. `reset` low → `locked`=0.
- Short and long entry:
  - 1,2,3, ENTER → `pin_error`.
  - 1,2,3,4,5, ENTER → fifth digit dropped, `digit_count`=4, `pin_valid`=1.
- CLEAR: 7,7, CLEAR, 1,2,3,4, ENTER → `digit_count` 2→0→4, `pin_valid`=1, `attempt_count`=0.
- Attempt retention: one wrong entry, card removed and reinserted, correct PIN → `attempt_count` reads 1 before ENTER and 0 after the match.
- Timeout (`PIN_TIMEOUT_EN`): card in, key 1, then 16 idle cycles → `pin_error` pulse, `attempt_count`=1, `digit_count`=0. A key on cycle 16 → no error.
